// File: rtl/fmul_pkg.sv
// fmul_pkg: shared definitions for the sequential multiplier.
//   - mode encoding for the six AVR multiply operations
//   - FSM state enum
//   - mode decode helpers (operand signedness, fractional shift)
package fmul_pkg;

  localparam logic [2:0] MODE_MUL    = 3'd0;
  localparam logic [2:0] MODE_MULS   = 3'd1;
  localparam logic [2:0] MODE_MULSU  = 3'd2;
  localparam logic [2:0] MODE_FMUL   = 3'd3;
  localparam logic [2:0] MODE_FMULS  = 3'd4;
  localparam logic [2:0] MODE_FMULSU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Multiplicand is signed for MULS, MULSU, FMULS, FMULSU.
  function automatic logic is_signed_rd(input logic [2:0] mode);
    return (mode == MODE_MULS)  || (mode == MODE_MULSU) ||
           (mode == MODE_FMULS) || (mode == MODE_FMULSU);
  endfunction

  // Multiplier is signed only for MULS and FMULS.
  function automatic logic is_signed_rr(input logic [2:0] mode);
    return (mode == MODE_MULS) || (mode == MODE_FMULS);
  endfunction

  // Fractional modes shift the product left by one. Reserved codes
  // fall through as plain MUL.
  function automatic logic is_frac(input logic [2:0] mode);
    return (mode == MODE_FMUL) || (mode == MODE_FMULS) || (mode == MODE_FMULSU);
  endfunction

endpackage

// File: rtl/fmul_shift_add.sv
// fmul_shift_add: unsigned WIDTH x WIDTH radix-2 shift-add core.
//   i_clk, i_rst : clock, async active-high reset
//   i_load       : clear accumulator/counter, latch operands i_a, i_b
//   i_step       : consume one multiplier bit (LSB first)
//   i_a, i_b     : multiplicand / multiplier magnitudes
//   o_acc        : running product (final after the last step)
//   o_last       : the step taken this cycle is the final one
module fmul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_last
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [W2-1:0]    r_a;   // multiplicand, pre-shifted to current bit weight
  logic [WIDTH-1:0] r_b;   // multiplier, shifted right so bit 0 is current
  logic [W2-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_a   <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a   <= {r_a[W2-2:0], 1'b0};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/fmul_seq.sv
// fmul_seq: multi-cycle AVR-style multiplier (MUL/MULS/MULSU/FMUL/FMULS/FMULSU).
//   i_clk, i_rst  : clock, async active-high reset
//   i_start       : request, accepted only while idle
//   i_mode        : operation select (6/7 behave as MUL)
//   i_rd, i_rr    : multiplicand, multiplier
//   o_busy        : operation in flight
//   o_done        : one-cycle pulse, result valid
//   o_r1, o_r0    : result high / low half
//   o_c, o_z      : carry (product msb before fractional shift), zero
// Sign-magnitude: magnitudes go through the unsigned core and the sign is
// reapplied once at the end, so -1.0 x -1.0 wraps to 0x80..0 as on AVR.
module fmul_seq
  import fmul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  input  logic [WIDTH-1:0] i_rd,
  input  logic [WIDTH-1:0] i_rr,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_r1,
  output logic [WIDTH-1:0] o_r0,
  output logic             o_c,
  output logic             o_z
);
  localparam int W2 = 2 * WIDTH;

  state_t     r_state;
  logic [2:0] r_mode;
  logic       r_sign;

  logic             w_neg_rd, w_neg_rr;
  logic [WIDTH-1:0] w_mag_rd, w_mag_rr;
  logic             w_load, w_step, w_last;
  logic [W2-1:0]    w_acc, w_p, w_r;

  assign w_neg_rd = is_signed_rd(i_mode) && i_rd[WIDTH-1];
  assign w_neg_rr = is_signed_rr(i_mode) && i_rr[WIDTH-1];
  // Most-negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign w_mag_rd = w_neg_rd ? -i_rd : i_rd;
  assign w_mag_rr = w_neg_rr ? -i_rr : i_rr;

  assign w_load = (r_state == ST_IDLE) && i_start;
  assign w_step = (r_state == ST_CALC);

  fmul_shift_add #(.WIDTH(WIDTH)) u_core (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (w_mag_rd),
    .i_b    (w_mag_rr),
    .o_acc  (w_acc),
    .o_last (w_last)
  );

  assign w_p = r_sign ? -w_acc : w_acc;
  assign w_r = is_frac(r_mode) ? {w_p[W2-2:0], 1'b0} : w_p;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_MUL;
      r_sign  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_r1    <= '0;
      o_r0    <= '0;
      o_c     <= 1'b0;
      o_z     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_sign  <= w_neg_rd ^ w_neg_rr;
            o_busy  <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          o_r1    <= w_r[W2-1:WIDTH];
          o_r0    <= w_r[WIDTH-1:0];
          o_c     <= w_p[W2-1];
          o_z     <= (w_r == '0);
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
